// File: rtl/iot_event_arbiter_pkg.sv
// Shared types and constants for the IoT event arbiter: FSM states,
// default device count and request-type encoding.
package iot_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE
   } state_t;

   localparam int unsigned N_DEV_DEF = 4;

   // Request type as driven onto the monitor's on_off line.
   localparam logic REQ_ON  = 1'b1;
   localparam logic REQ_OFF = 1'b0;

   function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage

// File: rtl/iot_event_arbiter_if.sv
// Device-side request/grant bundle between the devices and the arbiter.
interface iot_event_arbiter_if
   import iot_arb_pkg::*;
#(
   parameter int unsigned N_DEV = N_DEV_DEF
);
   logic [N_DEV-1:0] req_on;
   logic [N_DEV-1:0] req_off;
   logic [N_DEV-1:0] grant;

   modport master (output req_on, output req_off, input grant);
   modport slave  (input req_on, input req_off, output grant);
endinterface

// File: rtl/iot_event_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending bit at or after ptr,
// wrapping modulo N_DEV.
module rr_picker
   import iot_arb_pkg::*;
#(
   parameter int unsigned N_DEV = N_DEV_DEF
)(
   input  logic [N_DEV-1:0]         pending,
   input  logic [$clog2(N_DEV)-1:0] ptr,
   output logic [$clog2(N_DEV)-1:0] win,
   output logic                     valid
);
   localparam int unsigned IW = $clog2(N_DEV);

   logic [IW-1:0] idx;

   always_comb begin
      win   = '0;
      valid = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N_DEV; i++) begin
         idx = IW'(wrap_idx(int'(ptr) + i, N_DEV));
         if (!valid && pending[idx]) begin
            valid = 1'b1;
            win   = idx;
         end
      end
   end
endmodule

// File: rtl/iot_event_arbiter.sv
// Round-robin join/leave arbiter feeding single-cycle change/on_off pulses to
// the active-device monitor, with a per-device bitmap filtering duplicates.
module iot_event_arbiter
   import iot_arb_pkg::*;
#(
   parameter int unsigned N_DEV = N_DEV_DEF,
   parameter int unsigned CNT_W = 8
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   iot_event_arbiter_if.slave   dev,
   output logic                 mon_rst,
   output logic                 change,
   output logic                 on_off,
   output logic [N_DEV-1:0]     active_map,
   output logic [CNT_W-1:0]     active_cnt,
   output logic                 busy,
   output logic                 err
);
   localparam int unsigned IW = $clog2(N_DEV);

   state_t           state, state_nxt;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    win;
   logic             win_on;
   logic             win_off;
   logic [N_DEV-1:0] grant_q;
   logic [IW-1:0]    pick_win;
   logic             pick_valid;

   rr_picker #(.N_DEV(N_DEV)) u_picker (
      .pending (dev.req_on | dev.req_off),
      .ptr     (ptr),
      .win     (pick_win),
      .valid   (pick_valid)
   );

   assign dev.grant = grant_q;
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) state <= S_IDLE;
      else               state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (pick_valid) state_nxt = S_ISSUE;
         S_ISSUE:  state_nxt = S_SETTLE;
         S_SETTLE: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         ptr        <= '0;
         win        <= '0;
         win_on     <= 1'b0;
         win_off    <= 1'b0;
         grant_q    <= '0;
         change     <= 1'b0;
         on_off     <= 1'b0;
         active_map <= '0;
         active_cnt <= '0;
         mon_rst    <= 1'b1;
         if (!rst_n) err <= 1'b0;
      end else begin
         mon_rst <= 1'b0;
         grant_q <= '0;
         change  <= 1'b0;
         case (state)
            S_IDLE: if (pick_valid) begin
               win     <= pick_win;
               win_on  <= dev.req_on[pick_win];
               win_off <= dev.req_off[pick_win];
            end
            S_ISSUE: begin
               grant_q[win] <= 1'b1;
               ptr          <= (win == IW'(N_DEV - 1)) ? '0 : win + IW'(1);
               if (win_on && win_off) begin
                  err <= 1'b1;
               end else if (win_on && !active_map[win]) begin
                  change <= 1'b1;
                  on_off <= REQ_ON;
               end else if (win_off && active_map[win]) begin
                  change <= 1'b1;
                  on_off <= REQ_OFF;
               end
            end
            // The bitmap follows the pulse by one edge, keyed off the registered change.
            S_SETTLE: if (change) begin
               active_map[win] <= on_off;
               active_cnt      <= on_off ? active_cnt + CNT_W'(1) : active_cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_iot_event_arbiter.sv
// Directed bench for iot_event_arbiter: a vector table of single-device events
// plus hand-written sequences for arbitration order, clear and error cases.
module tb_iot_event_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       mon_rst, change, on_off, busy, err;
   logic [3:0] active_map;
   logic [7:0] active_cnt;
   int         n_checks = 0;
   int         n_fail   = 0;
   int         mon_cnt  = 0;

   iot_event_arbiter_if #(.N_DEV(4)) dev_if ();

   iot_event_arbiter #(.N_DEV(4), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .dev        (dev_if),
      .mon_rst    (mon_rst),
      .change     (change),
      .on_off     (on_off),
      .active_map (active_map),
      .active_cnt (active_cnt),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Reference monitor counter driven by the arbiter's monitor-side outputs.
   always @(posedge clk) begin
      if (mon_rst)     mon_cnt <= 0;
      else if (change) mon_cnt <= on_off ? mon_cnt + 1 : mon_cnt - 1;
   end

   typedef struct {
      logic [3:0] on;
      logic [3:0] off;
      logic [3:0] grant;
      logic       change;
      logic       on_off;
      logic [3:0] map;
      logic [7:0] cnt;
      logic       err;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One full IDLE -> ISSUE -> SETTLE event; request dropped once granted.
   task automatic do_event(input vec_t v);
      dev_if.req_on  = v.on;
      dev_if.req_off = v.off;
      tick();
      chk("busy_after_arb", 32'(busy), 32'd1);
      chk("grant_early", 32'(dev_if.grant), 32'd0);
      tick();
      chk("grant", 32'(dev_if.grant), 32'(v.grant));
      chk("change", 32'(change), 32'(v.change));
      chk("on_off", 32'(on_off), 32'(v.on_off));
      chk("err", 32'(err), 32'(v.err));
      dev_if.req_on  = '0;
      dev_if.req_off = '0;
      tick();
      chk("grant_settle", 32'(dev_if.grant), 32'd0);
      chk("change_settle", 32'(change), 32'd0);
      chk("map", 32'(active_map), 32'(v.map));
      chk("cnt", 32'(active_cnt), 32'(v.cnt));
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   task automatic wait_grant(output int waited);
      waited = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (dev_if.grant != 4'b0000) begin
            waited = i;
            break;
         end
      end
   endtask

   initial begin
      int         w;
      logic [3:0] exp_g;
      vec_t       v;

      vecs[0] = '{on: 4'b0100, off: 4'b0000, grant: 4'b0100, change: 1'b1, on_off: 1'b1, map: 4'b0101, cnt: 8'd2, err: 1'b0};
      vecs[1] = '{on: 4'b0100, off: 4'b0000, grant: 4'b0100, change: 1'b0, on_off: 1'b1, map: 4'b0101, cnt: 8'd2, err: 1'b0};
      vecs[2] = '{on: 4'b0000, off: 4'b0010, grant: 4'b0010, change: 1'b0, on_off: 1'b1, map: 4'b0101, cnt: 8'd2, err: 1'b0};
      vecs[3] = '{on: 4'b1000, off: 4'b0000, grant: 4'b1000, change: 1'b1, on_off: 1'b1, map: 4'b1101, cnt: 8'd3, err: 1'b0};
      vecs[4] = '{on: 4'b0000, off: 4'b0001, grant: 4'b0001, change: 1'b1, on_off: 1'b0, map: 4'b1100, cnt: 8'd2, err: 1'b0};
      vecs[5] = '{on: 4'b0000, off: 4'b0001, grant: 4'b0001, change: 1'b0, on_off: 1'b0, map: 4'b1100, cnt: 8'd2, err: 1'b0};
      vecs[6] = '{on: 4'b0001, off: 4'b0000, grant: 4'b0001, change: 1'b1, on_off: 1'b1, map: 4'b1101, cnt: 8'd3, err: 1'b0};

      rst_n = 1'b0;
      clr   = 1'b0;
      dev_if.req_on  = '0;
      dev_if.req_off = '0;
      repeat (3) tick();
      chk("rst_mon_rst", 32'(mon_rst), 32'd1);
      chk("rst_grant", 32'(dev_if.grant), 32'd0);
      chk("rst_change", 32'(change), 32'd0);
      chk("rst_on_off", 32'(on_off), 32'd0);
      chk("rst_map", 32'(active_map), 32'd0);
      chk("rst_cnt", 32'(active_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      // First join straight out of reset
      rst_n = 1'b1;
      v = '{on: 4'b0001, off: 4'b0000, grant: 4'b0001, change: 1'b1, on_off: 1'b1, map: 4'b0001, cnt: 8'd1, err: 1'b0};
      do_event(v);
      chk("mon_rst_released", 32'(mon_rst), 32'd0);

      for (int i = 0; i < 7; i++) do_event(vecs[i]);
      chk("mon_cnt_table", 32'(mon_cnt), 32'd3);

      // clr during ISSUE drops the in-flight join
      dev_if.req_on = 4'b0010;
      tick();
      clr = 1'b1;
      tick();
      chk("clr_mon_rst", 32'(mon_rst), 32'd1);
      chk("clr_grant", 32'(dev_if.grant), 32'd0);
      chk("clr_change", 32'(change), 32'd0);
      chk("clr_map", 32'(active_map), 32'd0);
      chk("clr_cnt", 32'(active_cnt), 32'd0);
      chk("clr_busy", 32'(busy), 32'd0);
      clr = 1'b0;
      dev_if.req_on = '0;
      tick();
      chk("clr_mon_rst_drop", 32'(mon_rst), 32'd0);
      chk("clr_no_grant", 32'(dev_if.grant), 32'd0);
      chk("clr_mon_cnt", 32'(mon_cnt), 32'd0);

      // All four join at once: round-robin order, 3 cycles apart
      dev_if.req_on = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         exp_g = 4'b0001 << k;
         wait_grant(w);
         chk("rr_grant", 32'(dev_if.grant), 32'(exp_g));
         chk("rr_wait", 32'(w), (k == 0) ? 32'd2 : 32'd3);
         chk("rr_change", 32'(change), 32'd1);
         dev_if.req_on = dev_if.req_on & ~exp_g;
      end
      tick();
      chk("rr_map", 32'(active_map), 32'hF);
      chk("rr_cnt", 32'(active_cnt), 32'd4);
      chk("rr_mon_cnt", 32'(mon_cnt), 32'd4);
      tick();

      // Redundant join on device 2 leaves ptr at 3
      v = '{on: 4'b0100, off: 4'b0000, grant: 4'b0100, change: 1'b0, on_off: 1'b1, map: 4'b1111, cnt: 8'd4, err: 1'b0};
      do_event(v);

      dev_if.req_off = 4'b1001;
      wait_grant(w);
      chk("off_first_grant", 32'(dev_if.grant), 32'h8);
      chk("off_first_wait", 32'(w), 32'd2);
      chk("off_first_on_off", 32'(on_off), 32'd0);
      chk("off_first_change", 32'(change), 32'd1);
      dev_if.req_off = 4'b0001;
      wait_grant(w);
      chk("off_second_grant", 32'(dev_if.grant), 32'h1);
      chk("off_second_wait", 32'(w), 32'd3);
      chk("off_second_on_off", 32'(on_off), 32'd0);
      chk("off_second_change", 32'(change), 32'd1);
      dev_if.req_off = '0;
      tick();
      chk("off_map", 32'(active_map), 32'h6);
      chk("off_cnt", 32'(active_cnt), 32'd2);
      chk("off_mon_cnt", 32'(mon_cnt), 32'd2);

      // Simultaneous join and leave on device 1
      v = '{on: 4'b0010, off: 4'b0010, grant: 4'b0010, change: 1'b0, on_off: 1'b0, map: 4'b0110, cnt: 8'd2, err: 1'b1};
      do_event(v);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("err_clr_err", 32'(err), 32'd1);
      chk("err_clr_map", 32'(active_map), 32'd0);
      chk("err_clr_cnt", 32'(active_cnt), 32'd0);
      chk("err_clr_mon_rst", 32'(mon_rst), 32'd1);
      tick();
      chk("err_sticky", 32'(err), 32'd1);
      chk("err_mon_rst_drop", 32'(mon_rst), 32'd0);

      rst_n = 1'b0;
      tick();
      chk("rst2_err", 32'(err), 32'd0);
      chk("rst2_mon_rst", 32'(mon_rst), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
